// File: rtl/debug_auth_ctrl.sv
// Purpose : debug authentication FSM; drives Lock/trusted/debug_mode of the lockable data register.
// Latency : every output is registered and moves one Clk cycle after the input edge that causes it.
// Flow    : no backpressure; key_valid/dbg_exit are single-cycle strobes, dbg_req is a level.
//
// Ports:
//   Clk, resetn            clock and asynchronous active-low reset
//   dbg_req                level, asks for a debug session (IDLE -> WAIT_KEY)
//   key_valid, key_in      strobe + 16-bit key candidate
//   dbg_exit               strobe, closes a session or abandons key entry
//   lock_req               software request to set the sticky Lock
//   Lock                   sticky lock, cleared only by reset
//   trusted, debug_mode    high only while an authenticated session is open
//   auth_fail              one-cycle pulse per wrong key
//   lockout_active         high while the lockout timer runs
//   fail_cnt               consecutive wrong key count
module debug_auth_ctrl #(
  parameter logic [15:0] KEY            = 16'hA5C3,
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1024,
  parameter int unsigned SESSION_CYCLES = 4096
) (
  input  logic        Clk,
  input  logic        resetn,
  input  logic        dbg_req,
  input  logic        key_valid,
  input  logic [15:0] key_in,
  input  logic        dbg_exit,
  input  logic        lock_req,
  output logic        Lock,
  output logic        trusted,
  output logic        debug_mode,
  output logic        auth_fail,
  output logic        lockout_active,
  output logic [3:0]  fail_cnt
);

  // One down-counter serves both the session and the lockout timers, as the
  // two states are mutually exclusive.
  localparam int unsigned CNT_MAX = (LOCKOUT_CYCLES > SESSION_CYCLES) ? LOCKOUT_CYCLES
                                                                      : SESSION_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] SESS_LOAD = CW'(SESSION_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]    MAX_CNT   = 4'(MAX_ATTEMPTS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_KEY,
    ST_SESSION,
    ST_LOCKOUT
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_fail_cnt;
  logic            r_lock;
  logic            r_session;
  logic            r_auth_fail;
  logic            r_lockout;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [3:0]      w_fail_nxt;
  logic [3:0]      w_fail_inc;
  logic            w_lock_nxt;
  logic            w_auth_fail_nxt;

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_fail_cnt  <= '0;
      r_lock      <= 1'b0;
      r_session   <= 1'b0;
      r_auth_fail <= 1'b0;
      r_lockout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_fail_cnt  <= w_fail_nxt;
      r_lock      <= w_lock_nxt;
      // Status flags are decoded from the next state so they are flop outputs
      // that line up exactly with the state they describe.
      r_session   <= (w_state_nxt == ST_SESSION);
      r_lockout   <= (w_state_nxt == ST_LOCKOUT);
      r_auth_fail <= w_auth_fail_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_fail_nxt      = r_fail_cnt;
    w_auth_fail_nxt = 1'b0;
    w_lock_nxt      = r_lock | lock_req;
    // Saturating increment; the FSM leaves WAIT_KEY at MAX_CNT anyway.
    w_fail_inc      = (r_fail_cnt < MAX_CNT) ? (r_fail_cnt + 4'd1) : r_fail_cnt;

    case (r_state)
      ST_IDLE: begin
        if (dbg_req) begin
          w_state_nxt = ST_WAIT_KEY;
        end
      end

      ST_WAIT_KEY: begin
        // Abort wins over a key presented in the same cycle.
        if (dbg_exit) begin
          w_state_nxt = ST_IDLE;
        end else if (key_valid) begin
          if (key_in == KEY) begin
            w_state_nxt = ST_SESSION;
            w_cnt_nxt   = SESS_LOAD;
            w_fail_nxt  = 4'd0;
          end else begin
            w_auth_fail_nxt = 1'b1;
            w_fail_nxt      = w_fail_inc;
            if (w_fail_inc == MAX_CNT) begin
              w_state_nxt = ST_LOCKOUT;
              w_cnt_nxt   = LOCK_LOAD;
              w_lock_nxt  = 1'b1;
            end
          end
        end
      end

      ST_SESSION: begin
        // Exit strobe and timer expiry collapse into one return to IDLE.
        if (dbg_exit || (r_cnt == '0)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end

      ST_LOCKOUT: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_fail_nxt  = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign Lock           = r_lock;
  assign trusted        = r_session;
  assign debug_mode     = r_session;
  assign auth_fail      = r_auth_fail;
  assign lockout_active = r_lockout;
  assign fail_cnt       = r_fail_cnt;

endmodule

// File: tb/tb_debug_auth_ctrl.sv
// Scoreboard bench for debug_auth_ctrl: stimulus pushes every expected output
// change (value + cycle), a negedge monitor pops one entry per observed change.
module tb_debug_auth_ctrl;

  localparam logic [15:0] KEY = 16'hA5C3;

  logic        Clk = 1'b0;
  logic        resetn = 1'b1;
  logic        dbg_req, key_valid, dbg_exit, lock_req;
  logic [15:0] key_in;
  logic        Lock, trusted, debug_mode, auth_fail, lockout_active;
  logic [3:0]  fail_cnt;

  debug_auth_ctrl #(
    .KEY(KEY), .MAX_ATTEMPTS(3), .LOCKOUT_CYCLES(1024), .SESSION_CYCLES(4096)
  ) dut (
    .Clk(Clk), .resetn(resetn), .dbg_req(dbg_req), .key_valid(key_valid),
    .key_in(key_in), .dbg_exit(dbg_exit), .lock_req(lock_req), .Lock(Lock),
    .trusted(trusted), .debug_mode(debug_mode), .auth_fail(auth_fail),
    .lockout_active(lockout_active), .fail_cnt(fail_cnt)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;   // -1: any cycle
    logic [8:0] val;   // {Lock,trusted,debug_mode,auth_fail,lockout_active,fail_cnt}
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [8:0] ov(input logic l, input logic t, input logic a,
                                    input logic la, input logic [3:0] f);
    return {l, t, t, a, la, f};
  endfunction

  task automatic push(input int c, input logic [8:0] v, input string nm);
    exp_t e;
    e.cyc = c;
    e.val = v;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: every change of the output vector must match the next expectation.
  logic [8:0] mon_prev = 9'h1FF;
  always @(negedge Clk) begin
    logic [8:0] w;
    exp_t e;
    w = {Lock, trusted, debug_mode, auth_fail, lockout_active, fail_cnt};
    if (w !== mon_prev) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change: got %b at cyc %0d, required no change from %b",
                 w, cyc, mon_prev);
      end else begin
        e = sb.pop_front();
        if ((w !== e.val) || ((e.cyc >= 0) && (e.cyc != cyc))) begin
          n_fail++;
          $display("FAIL %s: got %b at cyc %0d, required %b at cyc %0d",
                   e.nm, w, cyc, e.val, e.cyc);
        end
      end
      mon_prev = w;
    end
  end

  // Wrong key in WAIT_KEY that does not reach the lockout threshold.
  task automatic wrong_key(input logic [3:0] n, input string tag);
    int c;
    c = cyc;
    key_valid = 1'b1;
    key_in    = 16'h0000;
    push(c + 1, ov(1'b0, 1'b0, 1'b1, 1'b0, n), {tag, "_auth_fail"});
    push(c + 2, ov(1'b0, 1'b0, 1'b0, 1'b0, n), {tag, "_pulse_end"});
    tick();
    key_valid = 1'b0;
    tick();
  endtask

  initial begin
    int c;
    int d;
    dbg_req = 1'b0; key_valid = 1'b0; key_in = '0; dbg_exit = 1'b0; lock_req = 1'b0;
    push(-1, ov(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "reset_values");
    #2 resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    // 1: correct key, full-length session
    dbg_req = 1'b1; tick(); dbg_req = 1'b0;
    c = cyc;
    key_valid = 1'b1; key_in = KEY;
    push(c + 1,        ov(1'b0, 1'b1, 1'b0, 1'b0, 4'd0), "t1_session_open");
    push(c + 1 + 4096, ov(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "t1_session_expire");
    tick(); key_valid = 1'b0;
    repeat (4100) tick();

    // 2: three wrong keys -> lockout, Lock stays set afterwards
    dbg_req = 1'b1; tick(); dbg_req = 1'b0;
    wrong_key(4'd1, "t2_k1");
    wrong_key(4'd2, "t2_k2");
    c = cyc;
    key_valid = 1'b1; key_in = 16'h0000;
    push(c + 1,        ov(1'b1, 1'b0, 1'b1, 1'b1, 4'd3), "t2_lockout_enter");
    push(c + 2,        ov(1'b1, 1'b0, 1'b0, 1'b1, 4'd3), "t2_k3_pulse_end");
    push(c + 1 + 1024, ov(1'b1, 1'b0, 1'b0, 1'b0, 4'd0), "t2_lockout_end");
    tick(); key_valid = 1'b0;
    repeat (100) tick();
    // all inputs ignored during lockout
    dbg_req = 1'b1; key_valid = 1'b1; key_in = KEY; dbg_exit = 1'b1;
    tick();
    dbg_req = 1'b0; key_valid = 1'b0; dbg_exit = 1'b0;
    repeat (1000) tick();
    c = cyc;
    push(c, ov(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "t2_reset_clears_lock");
    resetn = 1'b0; tick(); resetn = 1'b1; tick();

    // 3: two wrong keys then the correct key
    dbg_req = 1'b1; tick(); dbg_req = 1'b0;
    wrong_key(4'd1, "t3_k1");
    wrong_key(4'd2, "t3_k2");
    c = cyc;
    key_valid = 1'b1; key_in = KEY;
    push(c + 1, ov(1'b0, 1'b1, 1'b0, 1'b0, 4'd0), "t3_open_clears_cnt");
    tick(); key_valid = 1'b0;
    repeat (4) tick();
    c = cyc;
    dbg_exit = 1'b1;
    push(c + 1, ov(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "t3_exit");
    tick(); dbg_exit = 1'b0; tick();

    // 4: exit + correct key together -> IDLE, fail_cnt kept
    dbg_req = 1'b1; tick(); dbg_req = 1'b0;
    wrong_key(4'd1, "t4_k1");
    dbg_exit = 1'b1; key_valid = 1'b1; key_in = KEY;
    tick();
    dbg_exit = 1'b0; key_valid = 1'b0;
    tick();
    key_valid = 1'b1; tick(); key_valid = 1'b0;   // must be ignored in IDLE
    repeat (3) tick();

    // 5: early exit at session cycle 10, dbg_req held, software lock
    dbg_req = 1'b1; tick();
    c = cyc;
    key_valid = 1'b1; key_in = KEY;
    push(c + 1, ov(1'b0, 1'b1, 1'b0, 1'b0, 4'd0), "t5_open");
    tick(); key_valid = 1'b0;
    repeat (8) tick();
    d = cyc;
    dbg_exit = 1'b1;
    push(d + 1, ov(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "t5_early_exit");
    tick(); dbg_exit = 1'b0;
    tick();   // IDLE -> WAIT_KEY with dbg_req still high
    c = cyc;
    key_valid = 1'b1;
    push(c + 1, ov(1'b0, 1'b1, 1'b0, 1'b0, 4'd0), "t5_reenter_wait_key");
    tick(); key_valid = 1'b0; dbg_req = 1'b0;
    repeat (3) tick();
    c = cyc;
    lock_req = 1'b1;
    push(c + 1, ov(1'b1, 1'b1, 1'b0, 1'b0, 4'd0), "t5_sw_lock");
    tick(); lock_req = 1'b0;
    repeat (3) tick();
    c = cyc;
    dbg_exit = 1'b1;
    push(c + 1, ov(1'b1, 1'b0, 1'b0, 1'b0, 4'd0), "t5_exit_lock_held");
    tick(); dbg_exit = 1'b0;
    repeat (20) tick();

    // 6: asynchronous reset mid-session
    dbg_req = 1'b1; tick(); dbg_req = 1'b0;
    c = cyc;
    key_valid = 1'b1; key_in = KEY;
    push(c + 1, ov(1'b1, 1'b1, 1'b0, 1'b0, 4'd0), "t6_open");
    tick(); key_valid = 1'b0;
    repeat (50) tick();
    c = cyc;
    push(c, ov(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "t6_async_reset");
    resetn = 1'b0;
    tick(); resetn = 1'b1; tick();
    key_valid = 1'b1; tick(); key_valid = 1'b0;   // IDLE after release: ignored
    repeat (3) tick();
    dbg_req = 1'b1; tick(); dbg_req = 1'b0;
    c = cyc;
    key_valid = 1'b1;
    push(c + 1, ov(1'b0, 1'b1, 1'b0, 1'b0, 4'd0), "t6_post_reset_open");
    tick(); key_valid = 1'b0;
    repeat (2) tick();
    c = cyc;
    dbg_exit = 1'b1;
    push(c + 1, ov(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "t6_exit");
    tick(); dbg_exit = 1'b0;
    repeat (5) tick();

    // Anything still queued is an expected change that never appeared.
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got no change, required %b at cyc %0d", e.nm, e.val, e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_auth_ctrl.md
# debug_auth_ctrl

Debug authentication controller that sits directly upstream of the lockable data register. It generates that register's `Lock`, `trusted` and `debug_mode` inputs. A debugger must present a matching 16-bit key before a time-limited trusted debug session opens. Repeated wrong keys force a lockout period and permanently assert `Lock` until reset.

## Interface
Parameters:
- `KEY`, 16'hA5C3, expected debug unlock key
- `MAX_ATTEMPTS`, 3, consecutive wrong keys that trigger lockout (1..15)
- `LOCKOUT_CYCLES`, 1024, length of the lockout period in Clk cycles (>=2)
- `SESSION_CYCLES`, 4096, maximum length of a debug session in Clk cycles (>=2)

Ports:
- `Clk`  input  1  single clock; all logic on its rising edge
- `resetn`  input  1  asynchronous, active-low reset
- `dbg_req`  input  1  level; request to open a debug session
- `key_valid`  input  1  one-cycle strobe qualifying `key_in`
- `key_in`  input  16  key candidate
- `dbg_exit`  input  1  one-cycle strobe; close session or abort key entry
- `lock_req`  input  1  software request to lock the register
- `Lock`  output  1  sticky lock to the register
- `trusted`  output  1  high only during an authenticated session
- `debug_mode`  output  1  high only during an authenticated session
- `auth_fail`  output  1  one-cycle pulse per wrong key
- `lockout_active`  output  1  high while in LOCKOUT
- `fail_cnt`  output  4  current count of consecutive wrong keys

## Operation
States: IDLE, WAIT_KEY, SESSION, LOCKOUT. Reset state is IDLE.
- **IDLE**
  - `trusted`, `debug_mode` and `lockout_active` are 0.
  - `dbg_req`=1 moves to WAIT_KEY.
- **WAIT_KEY**
  - `dbg_exit` moves to IDLE. It has priority over `key_valid` in the same cycle. `fail_cnt` is kept.
  - `key_valid` with `key_in`==KEY moves to SESSION, clears `fail_cnt` and loads the session counter with SESSION_CYCLES-1.
  - `key_valid` with a mismatched key pulses `auth_fail` and increments `fail_cnt`.
    - If the new count equals MAX_ATTEMPTS, move to LOCKOUT and load the lockout counter with LOCKOUT_CYCLES-1.
    - Otherwise stay in WAIT_KEY.
- **SESSION**
  - `trusted`=1 and `debug_mode`=1.
  - The counter decrements every cycle.
  - `dbg_exit`, or the counter reaching 0, moves to IDLE. If both happen in the same cycle, the result is a single transition to IDLE.
  - `key_valid` and `dbg_req` are ignored.
- **LOCKOUT**
  - `lockout_active`=1.
  - `Lock` is set on entry.
  - `dbg_req`, `key_valid` and `dbg_exit` are ignored.
  - The counter decrements every cycle. At 0, move to IDLE and clear `fail_cnt`.
- **`Lock` behaviour**
  - Set by `lock_req`=1 in any state, or on entry to LOCKOUT.
  - Never cleared except by `resetn`.
  - `Lock` has no effect on this FSM.
- **`fail_cnt` behaviour**
  - Saturates at MAX_ATTEMPTS.
  - Cleared only by a correct key, lockout expiry or reset.

## Timing
- **Output registration:** all outputs are registered and change one cycle after the causing input edge.
- **Reset values:** `Lock`=0, `trusted`=0, `debug_mode`=0, `auth_fail`=0, `lockout_active`=0, `fail_cnt`=0. Assertion of `resetn` forces these immediately, including mid-session or mid-lockout.
- **Key acceptance:** a correct key sampled at edge N gives `trusted`/`debug_mode` high from N+1.
- **Session length:** with no `dbg_exit`, `trusted`/`debug_mode` stay high for exactly SESSION_CYCLES cycles.
- **Lockout length:** `lockout_active` is high for exactly LOCKOUT_CYCLES cycles.
- **`auth_fail` pulse:** high for exactly 1 cycle, from N+1, for a wrong key at edge N. It is co-incident with the `fail_cnt` update.
- **`dbg_exit` in SESSION:** at edge N, outputs drop at N+1.
- **`dbg_req` held high:** on return to IDLE, `dbg_req` still high re-enters WAIT_KEY on the next edge. There is no automatic re-authentication.

## Test plan
1. **Reset:** reset, then `dbg_req`, then key 16'hA5C3 -> `trusted`=`debug_mode`=1 for 4096 cycles, then 0; `fail_cnt`=0.
2. **Lockout:** three wrong keys (16'h0000) -> `auth_fail` pulses 3×; `fail_cnt` 1,2,3; LOCKOUT with `Lock`=1, `lockout_active` high 1024 cycles; then `fail_cnt`=0 and `Lock` still 1.
3. **Recovery after wrong keys:** two wrong keys, then correct key -> SESSION, `fail_cnt`=0, `Lock`=0.
4. **Simultaneous strobes in WAIT_KEY:** `dbg_exit`+`key_valid` (correct key) same cycle -> IDLE; `trusted` stays 0.
5. **Early exit and software lock:** `dbg_exit` at cycle 10 of a session -> outputs low next cycle. `lock_req` pulse -> `Lock`=1 and held until `resetn` low.
6. **Reset mid-session:** `resetn` low mid-session -> all outputs 0 immediately; state is IDLE after release.
